// File: rtl/tick_pkg.sv
// tick_pkg: shared FSM state encoding and default parameters for the tick receiver.
package tick_pkg;
   typedef enum logic [1:0] {ARM, IDLE, MEAS, LONG} state_t;
   localparam int SYNC_STAGES_D = 2;
   localparam int WIDTH_W_D     = 8;
   localparam int COUNT_W_D     = 16;
   localparam int MIN_W_D       = 2;
   localparam int MAX_W_D       = 200;
endpackage

// File: rtl/tick_sync.sv
// tick_sync: STAGES-deep flop synchroniser, clears to 0 on reset.
//   i_clk, i_rst_n (async active-low), i_d raw input, o_q synchronised output.
module tick_sync #(
   parameter int STAGES = 2
)(
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);
   logic [STAGES-1:0] q;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) q <= '0;
      else q <= {q[STAGES-2:0], i_d};
   assign o_q = q[STAGES-1];
endmodule

// File: rtl/rcv_tick.sv
// rcv_tick: synchronises a tick line, measures its high width, validates it and
//   presents accepted ticks on a valid/ready interface.
//   i_clk, i_rst_n (async active-low), i_tick raw line, i_ready consumer accept,
//   i_clr clears count/overrun; o_valid/o_width pending tick, o_count accepted
//   ticks (wraps), o_err_short/o_err_long error pulses, o_overrun sticky drop flag.
module rcv_tick
   import tick_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_D,
   parameter int WIDTH_W     = WIDTH_W_D,
   parameter int COUNT_W     = COUNT_W_D,
   parameter int MIN_W       = MIN_W_D,
   parameter int MAX_W       = MAX_W_D
)(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_tick,
   input  logic               i_ready,
   input  logic               i_clr,
   output logic               o_valid,
   output logic [WIDTH_W-1:0] o_width,
   output logic [COUNT_W-1:0] o_count,
   output logic               o_err_short,
   output logic               o_err_long,
   output logic               o_overrun
);
   localparam logic [WIDTH_W-1:0] MIN_V = WIDTH_W'(MIN_W);
   localparam logic [WIDTH_W-1:0] MAX_V = WIDTH_W'(MAX_W);
   state_t                 st, st_nxt;
   logic [WIDTH_W-1:0]     wcnt, wcnt_nxt;
   logic [SYNC_STAGES-1:0] prime;
   logic                   s, acc, err_s, err_l, load, drop;

   tick_sync #(.STAGES(SYNC_STAGES)) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_tick),
      .o_q     (s)
   );

   // The synchroniser resets to 0, which would look like a low line; ARM only
   // trusts s once prime shows the chain holds real samples of i_tick.
   always_comb begin
      st_nxt   = st;
      wcnt_nxt = wcnt;
      acc      = 1'b0;
      err_s    = 1'b0;
      err_l    = 1'b0;
      unique case (st)
         ARM:  if (prime[SYNC_STAGES-1] && !s) st_nxt = IDLE;
         IDLE: if (s) begin
            st_nxt   = MEAS;
            wcnt_nxt = WIDTH_W'(1);
         end
         MEAS: if (s) begin
            if (wcnt >= MAX_V) st_nxt = LONG;
            else wcnt_nxt = wcnt + WIDTH_W'(1);
         end else begin
            st_nxt = IDLE;
            err_s  = wcnt < MIN_V;
            acc    = !err_s;
         end
         LONG: if (!s) begin
            st_nxt = IDLE;
            err_l  = 1'b1;
         end
      endcase
   end

   // A consumer ready on the same edge frees the slot for the new tick.
   assign load = acc & (~o_valid | i_ready);
   assign drop = acc & o_valid & ~i_ready;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         prime       <= '0;
         st          <= ARM;
         wcnt        <= '0;
         o_valid     <= 1'b0;
         o_width     <= '0;
         o_count     <= '0;
         o_err_short <= 1'b0;
         o_err_long  <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         prime       <= {prime[SYNC_STAGES-2:0], 1'b1};
         st          <= st_nxt;
         wcnt        <= wcnt_nxt;
         o_valid     <= load | (o_valid & ~i_ready);
         if (load) o_width <= wcnt;
         o_count     <= (i_clr ? '0 : o_count) + COUNT_W'(load);
         o_overrun   <= drop | (o_overrun & ~i_clr);
         o_err_short <= err_s;
         o_err_long  <= err_l;
      end
endmodule

// File: tb/tb_rcv_tick.sv
// tb_rcv_tick: directed vector bench for rcv_tick.
module tb_rcv_tick;
   logic        clk = 1'b0, rst_n = 1'b0, tick = 1'b0, ready = 1'b1, clr = 1'b0;
   logic        valid, es, el, ovr;
   logic [7:0]  width;
   logic [15:0] cnt;
   logic        valid4, es4, el4, ovr4;
   logic [7:0]  width4;
   logic [3:0]  cnt4;
   int          n_chk = 0, n_pass = 0;

   typedef struct {
      int   w;
      logic v;
      int   wd;
      logic s;
      logic l;
   } vec_t;
   vec_t tbl[7];

   always #5 clk = ~clk;

   rcv_tick dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_ready(ready), .i_clr(clr),
      .o_valid(valid), .o_width(width), .o_count(cnt),
      .o_err_short(es), .o_err_long(el), .o_overrun(ovr)
   );

   rcv_tick #(.COUNT_W(4)) dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_ready(1'b1), .i_clr(1'b0),
      .o_valid(valid4), .o_width(width4), .o_count(cnt4),
      .o_err_short(es4), .o_err_long(el4), .o_overrun(ovr4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic pulse(input int w);
      @(negedge clk);
      tick = 1'b1;
      repeat (w) @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst_n = 1'b0;
      tick  = 1'b0;
      clr   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_flags", {valid, es, el, ovr}, 0);
      chk("rst_count", cnt, 0);
      chk("rst_width", width, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int   exp_cnt;
      logic bad;
      tbl[0] = '{5,   1'b1, 5,   1'b0, 1'b0};
      tbl[1] = '{1,   1'b0, 0,   1'b1, 1'b0};
      tbl[2] = '{2,   1'b1, 2,   1'b0, 1'b0};
      tbl[3] = '{200, 1'b1, 200, 1'b0, 1'b0};
      tbl[4] = '{201, 1'b0, 0,   1'b0, 1'b1};
      tbl[5] = '{250, 1'b0, 0,   1'b0, 1'b1};
      tbl[6] = '{3,   1'b1, 3,   1'b0, 1'b0};

      // table: single pulses with ready high
      do_reset;
      ready   = 1'b1;
      exp_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         pulse(tbl[i].w);
         repeat (2) @(negedge clk);
         chk($sformatf("v%0d_early", i), {valid, es, el}, 0);
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), valid, tbl[i].v);
         chk($sformatf("v%0d_short", i), es, tbl[i].s);
         chk($sformatf("v%0d_long", i), el, tbl[i].l);
         if (tbl[i].v) chk($sformatf("v%0d_width", i), width, tbl[i].wd);
         exp_cnt += int'(tbl[i].v);
         chk($sformatf("v%0d_count", i), cnt, exp_cnt);
         @(negedge clk);
         chk($sformatf("v%0d_oneshot", i), {valid, es, el}, 0);
      end

      // overrun with ready held low
      do_reset;
      ready = 1'b0;
      pulse(4);
      repeat (3) @(negedge clk);
      chk("ovr_first_valid", valid, 1);
      chk("ovr_first_width", width, 4);
      pulse(6);
      repeat (3) @(negedge clk);
      chk("ovr_hold_valid", valid, 1);
      chk("ovr_hold_width", width, 4);
      chk("ovr_flag", ovr, 1);
      chk("ovr_count", cnt, 1);
      ready = 1'b1;
      @(negedge clk);
      chk("ovr_drain", valid, 0);
      pulse(3);
      repeat (3) @(negedge clk);
      chk("ovr_next_width", width, 3);
      chk("ovr_next_count", cnt, 2);

      // reset mid-pulse, released while line still high
      do_reset;
      @(negedge clk);
      tick = 1'b1;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_rst_flags", {valid, es, el, cnt}, 0);
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         bad |= valid | es | el;
      end
      tick = 1'b0;
      repeat (6) begin
         @(negedge clk);
         bad |= valid | es | el;
      end
      chk("mid_rst_quiet", bad, 0);
      pulse(3);
      repeat (3) @(negedge clk);
      chk("mid_rst_valid", valid, 1);
      chk("mid_rst_width", width, 3);
      chk("mid_rst_count", cnt, 1);

      // clear interactions
      do_reset;
      ready = 1'b1;
      repeat (6) begin
         pulse(3);
         repeat (4) @(negedge clk);
      end
      ready = 1'b0;
      repeat (2) begin
         pulse(3);
         repeat (4) @(negedge clk);
      end
      chk("clr_pre_count", cnt, 7);
      chk("clr_pre_ovr", ovr, 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_count", cnt, 0);
      chk("clr_ovr", ovr, 0);
      chk("clr_keeps_valid", {valid, width}, {1'b1, 8'd3});
      pulse(3);
      repeat (2) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_vs_overrun", ovr, 1);
      ready = 1'b1;
      pulse(2);
      repeat (4) @(negedge clk);
      chk("clr_acc_pre", cnt, 1);
      pulse(4);
      repeat (2) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_with_accept", cnt, 1);
      chk("clr_accept_width", width, 4);

      // count wrap on the narrow-counter instance
      do_reset;
      ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         pulse(2);
         repeat (4) @(negedge clk);
         if (i == 14) chk("wrap_15", cnt4, 15);
      end
      chk("wrap_wide", cnt, 16);
      chk("wrap_narrow", cnt4, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
